softmax_result_streamer: RTL and testbench
==========================================

// Module: softmax_result_streamer
// PURPOSE
//  Consumer end of the softmax datapath. Captures one parallel vector of SIZE
//  softmax words ({marker,Q0.16 prob}) and streams the elements out one per
//  handshake. Tracks the running argmax and flags malformed words (marker=0).
//  Sits between the combinational softmax array and the serial classifier and
//  result bus.
// PARAMETERS
//  SIZE   5   number of softmax elements per vector
//  W      17  softmax word width: bit W-1 = marker, bits W-2:0 = probability
//  IDX_W  3   element index width; must satisfy 2**IDX_W > SIZE
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous active-low reset
//  in_valid     in   1        in_vec holds a valid softmax vector
//  in_ready     out  1        streamer can accept a vector
//  in_vec       in   SIZE*W   element k (1..SIZE) at bits [(k-1)*W +: W]
//  out_valid    out  1        out_* carry a valid element
//  out_ready    in   1        downstream accepts the element
//  out_prob     out  W-1      probability field of the current element
//  out_idx      out  IDX_W    element index, 1..SIZE
//  out_err      out  1        marker bit of the current element was 0
//  out_last     out  1        current element is index SIZE
//  res_valid    out  1        one-cycle pulse: argmax result valid
//  res_idx      out  IDX_W    index of the maximum probability
//  res_prob     out  W-1      maximum probability value
//  res_err      out  1        at least one element in the vector had marker=0
// BEHAVIOUR
//  - All registers clear on the clk edge where rst_n=0. Reset values:
//    in_ready=0 while rst_n=0 and 1 from the first cycle after release.
//    All other outputs are 0.
//  - FSM states: IDLE -> STREAM -> RESULT -> IDLE.
//  - IDLE: in_ready=1 and out_valid=0.
//    - On in_valid&&in_ready, latch all SIZE words, set the element pointer
//      to 1, clear the running max/idx/err, and go to STREAM.
//    - out_valid rises on the next cycle, so latency is 1 cycle.
//  - STREAM: in_ready=0 and out_valid=1.
//    - out_prob, out_idx, out_err and out_last come from the latched word at
//      the pointer.
//    - Outputs stay stable while out_ready=0; there is no timeout.
//    - On out_valid&&out_ready:
//      - If the marker is 1 and prob > running max (strict), update max/idx.
//        Ties keep the lowest index.
//      - A word with marker=0 counts as prob 0 for argmax. It sets the sticky
//        err bit and is still streamed unmodified.
//      - The pointer increments. If out_last, go to RESULT instead.
//  - Argmax start: the running max starts at 0 and res_idx at 1. An all-zero
//    or all-error vector therefore reports idx=1 and prob=0.
//  - RESULT: lasts exactly one cycle.
//    - res_valid=1. res_idx, res_prob and res_err are driven.
//    - res_idx/prob/err then hold until the next vector is captured.
//    - out_valid=0 and in_ready=0, then go to IDLE.
//    - Throughput: SIZE+2 cycles per vector with no backpressure.
//  - No vector is accepted in STREAM or RESULT; in_vec is ignored there.
//  - Reset mid-STREAM aborts the vector. No res_valid is issued and the
//    next vector starts at index 1.
//  - The pointer never wraps past SIZE, and the comparison width is W-1
//    (unsigned).
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles with in_valid=1.
//    -> all outputs 0 and in_ready=0; in_ready=1 on the first cycle after
//       release.
//  - Basic, out_ready=1: probs {0x1000,0x4000,0x2000,0x3000,0x0800} with all
//    markers 1.
//    -> out_idx 1..5 on consecutive cycles, out_last on idx 5.
//    -> res_valid one cycle later with res_idx=2, res_prob=0x4000, res_err=0.
//  - Tie: probs {0x2000,0x5000,0x5000,0x1000,0x0000}.
//    -> res_idx=2, res_prob=0x5000.
//  - Error word: element 3 = 17'h0_FFFF (marker 0), others 0x0100.
//    -> out_err=1 only on idx 3, with out_prob=0xFFFF.
//    -> res_idx=1, res_prob=0x0100, res_err=1.
//  - Backpressure: drop out_ready for 4 cycles while idx=2 is presented.
//    -> out_* stable, in_ready=0, no extra elements; the sequence resumes
//       at idx 2.
//  - Reset mid-stream: assert rst_n=0 while idx=3 is presented.
//    -> no res_valid pulse.
//    -> the next vector streams from idx=1 with a correct argmax.

Source files
------------

// File: rtl/softmax_result_streamer.sv
// Captures one softmax vector, streams its elements one per handshake and
// reports the argmax (strict greater-than, lowest index wins ties) at the end.
module softmax_result_streamer #(
    parameter int SIZE  = 5,
    parameter int W     = 17,
    parameter int IDX_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE*W-1:0]   in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-2:0]        out_prob,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_err,
    output logic                out_last,
    output logic                res_valid,
    output logic [IDX_W-1:0]    res_idx,
    output logic [W-2:0]        res_prob,
    output logic                res_err
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        RESULT
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [W-1:0]       words [SIZE];
    logic [IDX_W-1:0]   ptr;
    logic [W-2:0]       run_max;
    logic [IDX_W-1:0]   run_idx;
    logic               run_err;

    logic [W-1:0]       cur_word;
    logic               cur_last;
    logic               take_in;
    logic               take_out;

    // Pointer is 1-based; a compare-mux avoids an out-of-range array index.
    always_comb begin
        cur_word = '0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            if (ptr == IDX_W'(k + 1)) begin
                cur_word = words[k];
            end
        end
    end

    assign cur_last  = (ptr == IDX_W'(SIZE));
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == STREAM);
    assign take_in   = in_valid && in_ready;
    assign take_out  = out_valid && out_ready;

    assign out_prob  = out_valid ? cur_word[W-2:0] : '0;
    assign out_idx   = out_valid ? ptr : '0;
    assign out_err   = out_valid && !cur_word[W-1];
    assign out_last  = out_valid && cur_last;

    assign res_valid = (state == RESULT);
    assign res_idx   = run_idx;
    assign res_prob  = run_max;
    assign res_err   = run_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take_in) state_nx = STREAM;
            STREAM:  if (take_out && cur_last) state_nx = RESULT;
            RESULT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SIZE; k++) begin
                words[k] <= '0;
            end
            ptr     <= '0;
            run_max <= '0;
            run_idx <= '0;
            run_err <= 1'b0;
        end else if (take_in) begin
            for (int unsigned k = 0; k < SIZE; k++) begin
                words[k] <= in_vec[k*W +: W];
            end
            ptr     <= IDX_W'(1);
            run_max <= '0;
            run_idx <= IDX_W'(1);
            run_err <= 1'b0;
        end else if (take_out) begin
            // Error words take part as probability 0, so they can never win.
            if (cur_word[W-1] && (cur_word[W-2:0] > run_max)) begin
                run_max <= cur_word[W-2:0];
                run_idx <= ptr;
            end
            if (!cur_word[W-1]) begin
                run_err <= 1'b1;
            end
            if (!cur_last) begin
                ptr <= ptr + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_softmax_result_streamer.sv
// Directed bench for softmax_result_streamer: table of vectors with hand-computed
// argmax results, plus backpressure and mid-stream reset sequences.
module tb_softmax_result_streamer;

    localparam int SIZE  = 5;
    localparam int W     = 17;
    localparam int IDX_W = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [SIZE*W-1:0]   in_vec;
    logic                out_valid;
    logic                out_ready;
    logic [W-2:0]        out_prob;
    logic [IDX_W-1:0]    out_idx;
    logic                out_err;
    logic                out_last;
    logic                res_valid;
    logic [IDX_W-1:0]    res_idx;
    logic [W-2:0]        res_prob;
    logic                res_err;

    int errors = 0;
    int checks = 0;

    softmax_result_streamer #(.SIZE(SIZE), .W(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prob  (out_prob),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .out_last  (out_last),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_prob  (res_prob),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0][15:0] p;     // p[k-1] is element k
        logic [4:0]       m;     // m[k-1] is the marker of element k
        logic [2:0]       idx;   // expected res_idx
        logic [15:0]      prob;  // expected res_prob
        logic             err;   // expected res_err
    } vec_t;

    vec_t tbl [6];

    function automatic vec_t mkv(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d,
                                 input logic [15:0] e, input logic [4:0] mk,
                                 input logic [2:0] ei, input logic [15:0] ep,
                                 input logic ee);
        vec_t v;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d; v.p[4] = e;
        v.m = mk; v.idx = ei; v.prob = ep; v.err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_elem(input int k, input vec_t v);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_idx",   32'(out_idx),   32'(k));
        chk("out_prob",  32'(out_prob),  32'(v.p[k-1]));
        chk("out_err",   32'(out_err),   32'(!v.m[k-1]));
        chk("out_last",  32'(out_last),  32'(k == 5));
        chk("in_ready_stream",  32'(in_ready),  32'd0);
        chk("res_valid_stream", 32'(res_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int stall_k, input int abort_k);
        logic [SIZE*W-1:0] iv;
        for (int k = 0; k < SIZE; k++) iv[k*W +: W] = {v.m[k], v.p[k]};
        @(negedge clk);
        chk("in_ready_idle",  32'(in_ready),  32'd1);
        chk("out_valid_idle", 32'(out_valid), 32'd0);
        in_vec   = iv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = ~iv;
        for (int k = 1; k <= SIZE; k++) begin
            @(negedge clk);
            chk_elem(k, v);
            if (k == abort_k) begin
                rst_n = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_res_valid", 32'(res_valid), 32'd0);
                    chk("abort_out_valid", 32'(out_valid), 32'd0);
                    chk("abort_in_ready",  32'(in_ready),  32'd0);
                end
                rst_n = 1'b1;
                return;
            end
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk_elem(k, v);
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_idx",   32'(res_idx),   32'(v.idx));
        chk("res_prob",  32'(res_prob),  32'(v.prob));
        chk("res_err",   32'(res_err),   32'(v.err));
        chk("out_valid_result", 32'(out_valid), 32'd0);
        chk("in_ready_result",  32'(in_ready),  32'd0);
        @(negedge clk);
        chk("res_valid_pulse", 32'(res_valid), 32'd0);
        chk("res_idx_hold",    32'(res_idx),   32'(v.idx));
        chk("res_prob_hold",   32'(res_prob),  32'(v.prob));
        chk("in_ready_back",   32'(in_ready),  32'd1);
    endtask

    initial begin
        tbl[0] = mkv(16'h1000, 16'h4000, 16'h2000, 16'h3000, 16'h0800, 5'b11111, 3'd2, 16'h4000, 1'b0);
        tbl[1] = mkv(16'h2000, 16'h5000, 16'h5000, 16'h1000, 16'h0000, 5'b11111, 3'd2, 16'h5000, 1'b0);
        tbl[2] = mkv(16'h0100, 16'h0100, 16'hFFFF, 16'h0100, 16'h0100, 5'b11011, 3'd1, 16'h0100, 1'b1);
        tbl[3] = mkv(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b11111, 3'd1, 16'h0000, 1'b0);
        tbl[4] = mkv(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF, 5'b11111, 3'd5, 16'hFFFF, 1'b0);
        tbl[5] = mkv(16'h7000, 16'h8000, 16'h9000, 16'hA000, 16'hB000, 5'b00000, 3'd1, 16'h0000, 1'b1);

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_vec    = '1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready",  32'(in_ready),  32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_bus",   32'({out_prob, out_idx, out_err, out_last}), 32'd0);
            chk("rst_res_bus",   32'({res_valid, res_idx, res_prob, res_err}), 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], 0, 0);

        run_vec(tbl[0], 2, 0);
        run_vec(tbl[1], 0, 3);
        run_vec(tbl[4], 0, 0);
        run_vec(tbl[2], 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (errors=%0d)", errors);
        $fatal(1, "timeout");
    end

endmodule
